vector_loader: RTL and testbench
================================

# vector_loader

Sequential front-end for the parallel dot-product stage. Accepts one float32 element pair (a, b) per cycle over a valid/ready stream and assembles two VLEN-wide packed vectors. Presents them on a valid/ready output whose data buses connect directly to the combinational dot-product inputs A and B. Short vectors are terminated early by `in_last` and zero-padded, so the downstream sum is unaffected.

## Interface
- `VLEN`, default 4: elements per vector; must be ≥ 1.
- `LW`, default `$clog2(VLEN+1)`: width of the length field.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  element pair available.
- `in_ready`  out  1  loader can accept an element this cycle.
- `in_a`  in  32  float32 element of vector A.
- `in_b`  in  32  float32 element of vector B.
- `in_last`  in  1  this element closes the vector.
- `out_valid`  out  1  packed vectors are valid.
- `out_ready`  in  1  consumer accepts the vectors.
- `out_a`  out  32*VLEN  packed A; element i at `[32*i +: 32]`.
- `out_b`  out  32*VLEN  packed B; same layout as `out_a`.
- `out_len`  out  LW  number of real elements, 1..VLEN.

## Operation
- **Element handshake.** An element is accepted when `in_valid && in_ready`. The first accepted element goes to index 0, then 1, 2, and so on, tracked by a write index.
- **Vector close.** A vector closes on the element carrying `in_last`, or on element VLEN-1, whichever comes first.
  - `in_last` on element VLEN-1 is legal.
  - An element VLEN-1 without `in_last` also closes the vector. The next accepted element starts a new vector.
- **Padding.** On close, slots above the last written index hold 32'h0000_0000 (+0.0). Banks are cleared to zero when released, so padding needs no extra cycle.
- **State machine, per bank.**
  - FILL → HOLD on the closing element's handshake.
  - HOLD → FILL on `out_valid && out_ready`. The bank and its length are cleared in that same edge.
- **Single-buffer mode.**
  - `in_ready = (state == FILL)`.
  - `out_valid = (state == HOLD)`.
  - Input and output handshakes never coincide.
- **Output stability.** While `out_valid` is high and `out_ready` is low, `out_a`, `out_b` and `out_len` are held stable.
- **Arithmetic.** None. Data is passed bit-exact; NaN, Inf and denormal values are stored untouched.
- **Reset.** Asserting `rst_n` low mid-fill or mid-hold discards all partial or held data.

## Timing
- **Reset values:**
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_a` = 0, `out_b` = 0, `out_len` = 0
  - write index = 0; all banks empty (FILL).
- **Latency.** `out_valid` rises the cycle after the closing element's handshake.
- **Minimum vector period, single buffer:** N + 1 cycles for an N-element vector with `out_ready` held high.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- `out_valid` does not depend combinationally on `in_valid`.
- After the output handshake edge, `in_ready` is high in the next cycle.

## Configuration
- **Macro:** `VECTOR_LOADER_DBUF_EN`.
- **Defined:** two banks with a 1-bit fill pointer and a 1-bit drain pointer.
  - The next vector fills while the other bank is held.
  - `in_ready` is low only when both banks are in HOLD.
  - Output order equals input order.
  - In the same cycle, a bank may release on the output side while the other bank accepts an element.
  - Sustained throughput is one element per cycle when `out_ready` is high.
- **Undefined:** single bank, behaving as described in Operation.
- Port list is identical in both builds.

## Structure
- **Shared package:**
  - `FP_WIDTH = 32`
  - `FP_ZERO = 32'h0000_0000`
  - typedef for the bank state (FILL, HOLD)
  - length-width helper function
- **Sub-module:** `vector_loader_bank`, instantiated once or twice.
  - Holds per-bank storage, length, state and clear-on-release.
  - The top level owns the pointers and the handshake logic.

## Test plan
- **Full vector.** VLEN=4; feed a = 1.0, 2.0, 3.0, 4.0 (32'h3F800000, 40000000, 40400000, 40800000) with `in_last` on the 4th element.
  - Expect: `out_valid` the next cycle, `out_a` = {40800000, 40400000, 40000000, 3F800000}, `out_len` = 4.
- **Short vector.** 2 elements with `in_last` on the 2nd.
  - Expect: `out_len` = 2, slots 2–3 of `out_a` and `out_b` = 0.
- **Backpressure.** Hold `out_ready` low 5 cycles after close.
  - Expect: outputs stable, `in_ready` low (single buffer).
  - Raise `out_ready`: `in_ready` high the next cycle.
- **Double buffer** (`VECTOR_LOADER_DBUF_EN`). Hold `out_ready` low and feed two vectors back-to-back.
  - Expect: second vector accepted while the first is held; `in_ready` low only after the second closes.
  - Then two output handshakes, in order.
- **Reset mid-fill.** Accept 2 elements, then pulse `rst_n` low between clock edges.
  - Expect: immediate `out_valid` = 0.
  - Next vector lands at index 0 with zeros elsewhere.
- **No `in_last`.** 5 elements with VLEN=4 and no `in_last`.
  - Expect: first vector closes at the 4th element with `out_len` = 4; the 5th element becomes index 0 of the next vector.

Source files
------------

// File: rtl/vector_loader_pkg.sv
// Shared types and constants for the vector_loader element-to-vector front end.
package vector_loader_pkg;

    localparam int unsigned FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic {
        BANK_FILL = 1'b0,
        BANK_HOLD = 1'b1
    } bank_state_t;

    // Width needed to hold a count in the range 0..n.
    function automatic int unsigned len_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vector_loader_bank.sv
// One vector bank: element storage, length and FILL/HOLD state, cleared to zero on release.
module vector_loader_bank
    import vector_loader_pkg::*;
#(
    parameter int unsigned VLEN = 4,
    parameter int unsigned LW   = len_width(VLEN),
    parameter int unsigned IW   = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic [FP_WIDTH-1:0]      wr_a,
    input  logic [FP_WIDTH-1:0]      wr_b,
    input  logic                     wr_close,
    input  logic                     rel_en,
    output bank_state_t              state,
    output logic [FP_WIDTH*VLEN-1:0] data_a,
    output logic [FP_WIDTH*VLEN-1:0] data_b,
    output logic [LW-1:0]            len
);

    bank_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BANK_FILL: if (wr_en && wr_close) state_d = BANK_HOLD;
            BANK_HOLD: if (rel_en)            state_d = BANK_FILL;
            default:                          state_d = BANK_FILL;
        endcase
    end

    // Clearing on release keeps unwritten slots at +0.0, so a short vector is already padded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
            len    <= '0;
        end else if (rel_en) begin
            data_a <= '0;
            data_b <= '0;
            len    <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < VLEN; i++) begin
                if (wr_idx == IW'(i)) begin
                    data_a[i*FP_WIDTH +: FP_WIDTH] <= wr_a;
                    data_b[i*FP_WIDTH +: FP_WIDTH] <= wr_b;
                end
            end
            if (wr_close) begin
                len <= LW'(wr_idx) + LW'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: rtl/vector_loader.sv
// Assembles streamed float32 pairs into VLEN-wide packed vectors for the dot-product stage.
// Define VECTOR_LOADER_DBUF_EN for a ping-pong pair of banks; otherwise a single bank is used.
module vector_loader
    import vector_loader_pkg::*;
#(
    parameter int unsigned VLEN = 4,
    parameter int unsigned LW   = len_width(VLEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32*VLEN-1:0]       out_a,
    output logic [32*VLEN-1:0]       out_b,
    output logic [LW-1:0]            out_len
);

    localparam int unsigned IW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(VLEN - 1);

`ifdef VECTOR_LOADER_DBUF_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    bank_state_t               bank_st [NB];
    logic [FP_WIDTH*VLEN-1:0]  bank_a  [NB];
    logic [FP_WIDTH*VLEN-1:0]  bank_b  [NB];
    logic [LW-1:0]             bank_len[NB];
    logic [NB-1:0]             fill_sel;
    logic [NB-1:0]             drain_sel;

    logic [IW-1:0] wr_idx;
    logic          in_fire;
    logic          in_close;
    logic          out_fire;

    assign in_fire  = in_valid && in_ready;
    assign in_close = in_last || (wr_idx == LAST_IDX);
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
        end else if (in_fire) begin
            wr_idx <= in_close ? '0 : wr_idx + 1'b1;
        end
    end

`ifdef VECTOR_LOADER_DBUF_EN
    logic fill_ptr;
    logic drain_ptr;

    // Both pointers advance through the banks in the same order, which keeps output order equal to input order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
        end else begin
            if (in_fire && in_close) fill_ptr  <= ~fill_ptr;
            if (out_fire)            drain_ptr <= ~drain_ptr;
        end
    end

    assign fill_sel  = {fill_ptr, ~fill_ptr};
    assign drain_sel = {drain_ptr, ~drain_ptr};
    assign in_ready  = (bank_st[fill_ptr] == BANK_FILL);
    assign out_valid = (bank_st[drain_ptr] == BANK_HOLD);
    assign out_a     = bank_a[drain_ptr];
    assign out_b     = bank_b[drain_ptr];
    assign out_len   = bank_len[drain_ptr];
`else
    assign fill_sel  = 1'b1;
    assign drain_sel = 1'b1;
    assign in_ready  = (bank_st[0] == BANK_FILL);
    assign out_valid = (bank_st[0] == BANK_HOLD);
    assign out_a     = bank_a[0];
    assign out_b     = bank_b[0];
    assign out_len   = bank_len[0];
`endif

    for (genvar g = 0; g < NB; g++) begin : g_bank
        vector_loader_bank #(
            .VLEN (VLEN),
            .LW   (LW),
            .IW   (IW)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (in_fire && fill_sel[g]),
            .wr_idx   (wr_idx),
            .wr_a     (in_a),
            .wr_b     (in_b),
            .wr_close (in_close),
            .rel_en   (out_fire && drain_sel[g]),
            .state    (bank_st[g]),
            .data_a   (bank_a[g]),
            .data_b   (bank_b[g]),
            .len      (bank_len[g])
        );
    end

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader: directed table, corner sequences and a randomized queue model.
module tb_vector_loader;

    localparam int unsigned VL = 4;
`ifdef VECTOR_LOADER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif
    localparam int unsigned CAP = DBUF ? 2 : 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [32*VL-1:0] out_a;
    logic [32*VL-1:0] out_b;
    logic [2:0]      out_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vector_loader #(.VLEN(VL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_len   (out_len)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic last, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         v;
        logic [31:0]  a;
        logic [31:0]  b;
        logic         last;
        logic         ordy;
        logic         rdy_sb;
        logic         rdy_db;
        logic         valid;
        logic [2:0]   len;
        logic [127:0] ea;
        logic [127:0] eb;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic last, input logic ordy, input logic rdy_sb,
                                input logic rdy_db, input logic valid, input logic [2:0] len,
                                input logic [127:0] ea, input logic [127:0] eb);
        row_t r;
        r.v = v; r.a = a; r.b = b; r.last = last; r.ordy = ordy;
        r.rdy_sb = rdy_sb; r.rdy_db = rdy_db; r.valid = valid; r.len = len;
        r.ea = ea; r.eb = eb;
        return r;
    endfunction

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        int unsigned  len;
    } vec_t;

    vec_t        mq[$];
    logic [31:0] pa[VL];
    logic [31:0] pb[VL];
    int unsigned pcnt;

    initial begin
        logic [127:0] full_a, full_b, sh_a, sh_b, nl_a, nl_b, n5_a, n5_b, r_a, r_b;
        logic exp_rdy, exp_vld, ifire, ofire;
        vec_t nv;

        full_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        full_b = {32'h80000000, 32'h00000001, 32'hFF800000, 32'h7FC00001};
        sh_a   = {32'h0, 32'h0, 32'h3EAAAAAB, 32'hC0490FDB};
        sh_b   = {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678};
        nl_a   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        nl_b   = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        n5_a   = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        n5_b   = {32'h0, 32'h0, 32'h0, 32'hCAFEF00D};

        // Full vector, then five cycles of backpressure, then release.
        rows.push_back(mk(1, 32'h3F800000, 32'h7FC00001, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h40000000, 32'hFF800000, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h40400000, 32'h00000001, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h40800000, 32'h80000000, 1, 0, 0, 1, 1, 4, full_a, full_b));
        for (int i = 0; i < 5; i++)
            rows.push_back(mk(0, '0, '0, 0, 0, 0, 1, 1, 4, full_a, full_b));
        rows.push_back(mk(0, '0, '0, 0, 1, 1, 1, 0, 0, '0, '0));
        // Short vector with zero padding.
        rows.push_back(mk(1, 32'hC0490FDB, 32'h12345678, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h3EAAAAAB, 32'h9ABCDEF0, 1, 0, 0, 1, 1, 2, sh_a, sh_b));
        rows.push_back(mk(0, '0, '0, 0, 1, 1, 1, 0, 0, '0, '0));
        // Five elements, no in_last: closes at the 4th, the 5th starts a new vector.
        rows.push_back(mk(1, 32'h11111111, 32'h55555555, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h22222222, 32'h66666666, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h33333333, 32'h77777777, 0, 0, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'h44444444, 32'h88888888, 0, 0, 0, 1, 1, 4, nl_a, nl_b));
        rows.push_back(mk(0, '0, '0, 0, 1, 1, 1, 0, 0, '0, '0));
        rows.push_back(mk(1, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0, 0, 1, 1, 1, n5_a, n5_b));
        rows.push_back(mk(0, '0, '0, 0, 1, 1, 1, 0, 0, '0, '0));

        // Reset state, both during and just after reset.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_len", out_len, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        foreach (rows[i]) begin
            drive(rows[i].v, rows[i].a, rows[i].b, rows[i].last, rows[i].ordy);
            step();
            chk($sformatf("row%0d_in_ready", i), in_ready, DBUF ? rows[i].rdy_db : rows[i].rdy_sb);
            chk($sformatf("row%0d_out_valid", i), out_valid, rows[i].valid);
            if (rows[i].valid) begin
                chk($sformatf("row%0d_out_len", i), out_len, rows[i].len);
                chk($sformatf("row%0d_out_a", i), out_a, rows[i].ea);
                chk($sformatf("row%0d_out_b", i), out_b, rows[i].eb);
            end
        end
        drive(0, '0, '0, 0, 0);

        // Reset mid-fill: two elements accepted, then an asynchronous pulse between edges.
        drive(1, 32'hAAAA0001, 32'hBBBB0001, 0, 0); step();
        drive(1, 32'hAAAA0002, 32'hBBBB0002, 0, 0); step();
        drive(0, '0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midfill_rst_out_valid", out_valid, 0);
        chk("midfill_rst_in_ready", in_ready, 1);
        chk("midfill_rst_out_a", out_a, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 32'h01020304, 32'h05060708, 1, 0); step();
        drive(0, '0, '0, 0, 0);
        chk("after_rst_out_valid", out_valid, 1);
        chk("after_rst_out_len", out_len, 1);
        chk("after_rst_out_a", out_a, {96'h0, 32'h01020304});
        chk("after_rst_out_b", out_b, {96'h0, 32'h05060708});

        // Reset mid-hold discards the held vector immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("midhold_rst_out_valid", out_valid, 0);
        chk("midhold_rst_out_len", out_len, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midhold_after_out_valid", out_valid, 0);
        chk("midhold_after_in_ready", in_ready, 1);

`ifdef VECTOR_LOADER_DBUF_EN
        // Two vectors back-to-back under backpressure, then drained in order.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'hF0000000 + i, 32'hE0000000 + i, (i == 3) || (i == 5), 0);
            step();
            chk($sformatf("dbuf_fill%0d_in_ready", i), in_ready, (i == 5) ? 0 : 1);
            chk($sformatf("dbuf_fill%0d_out_valid", i), out_valid, (i >= 3) ? 1 : 0);
        end
        chk("dbuf_first_a", out_a, {32'hF0000003, 32'hF0000002, 32'hF0000001, 32'hF0000000});
        chk("dbuf_first_len", out_len, 4);
        drive(0, '0, '0, 0, 1); step();
        chk("dbuf_second_valid", out_valid, 1);
        chk("dbuf_second_len", out_len, 2);
        chk("dbuf_second_a", out_a, {64'h0, 32'hF0000005, 32'hF0000004});
        chk("dbuf_second_b", out_b, {64'h0, 32'hE0000005, 32'hE0000004});
        chk("dbuf_second_in_ready", in_ready, 1);
        step();
        chk("dbuf_drained_valid", out_valid, 0);
        drive(0, '0, '0, 0, 0);
`endif

        // Randomized traffic against a queue-of-vectors model.
        do_reset();
        @(negedge clk);
        mq.delete();
        pcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            exp_rdy = (mq.size() < CAP);
            exp_vld = (mq.size() > 0);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, exp_vld);
            if (exp_vld) begin
                chk("rnd_out_len", out_len, mq[0].len);
                chk("rnd_out_a", out_a, mq[0].a);
                chk("rnd_out_b", out_b, mq[0].b);
            end
            drive($urandom_range(0, 9) < 7, $urandom, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
            ifire = in_valid && exp_rdy;
            ofire = out_ready && exp_vld;
            @(posedge clk);
            if (ofire) void'(mq.pop_front());
            if (ifire) begin
                pa[pcnt] = in_a;
                pb[pcnt] = in_b;
                pcnt++;
                if (in_last || pcnt == VL) begin
                    r_a = '0;
                    r_b = '0;
                    for (int unsigned k = 0; k < pcnt; k++) begin
                        r_a[k*32 +: 32] = pa[k];
                        r_b[k*32 +: 32] = pb[k];
                    end
                    nv.a = r_a;
                    nv.b = r_b;
                    nv.len = pcnt;
                    mq.push_back(nv);
                    pcnt = 0;
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
